// File: rtl/solo_squash_inputs_if.sv
// rtl/solo_squash_inputs_if.sv - button input and conditioned control signals of the solo_squash input block
interface solo_squash_inputs_if;
    logic [3:0] btn_n;
    logic [3:0] pressed;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic       paused;
    logic       new_game;
    logic       paddle_up;
    logic       paddle_down;
    logic       tick;

    modport slave (
        input  btn_n,
        output pressed, press_pulse, release_pulse, paused, new_game,
               paddle_up, paddle_down, tick
    );

    modport master (
        output btn_n,
        input  pressed, press_pulse, release_pulse, paused, new_game,
               paddle_up, paddle_down, tick
    );
endinterface

// File: rtl/solo_squash_inputs.sv
// rtl/solo_squash_inputs.sv - synchronise, debounce and edge-detect the solo_squash pushbuttons
module solo_squash_inputs #(
    parameter int TICK_DIV    = 25000,
    parameter int DB_COUNT    = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 reset_n,
    solo_squash_inputs_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DB_COUNT - 1);

    logic [PW-1:0]          pcnt;
    logic [PW-1:0]          pcnt_next;
    logic                   tick;
    logic [SYNC_STAGES-1:0] sync_q [4];
    logic [3:0]             s;
    logic [3:0]             db;
    logic [3:0]             db_next;
    logic [CW-1:0]          cnt      [4];
    logic [CW-1:0]          cnt_next [4];
    logic [3:0]             press_pulse;
    logic [3:0]             release_pulse;
    logic                   paused;

    // tick is registered so it reads 0 during reset even when TICK_DIV is 1
    assign pcnt_next = (pcnt == PCNT_LAST) ? '0 : pcnt + PW'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else begin
            pcnt <= pcnt_next;
            tick <= (pcnt_next == PCNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset_n)
                sync_q[i] <= '1;
            else
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.btn_n[i]};
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++)
            s[i] = sync_q[i][SYNC_STAGES-1];
    end

    // any sample that agrees with the accepted level restarts the count
    always_comb begin
        db_next = db;
        for (int i = 0; i < 4; i++) begin
            cnt_next[i] = cnt[i];
            if (s[i] == db[i]) begin
                cnt_next[i] = '0;
            end else if (tick) begin
                if (cnt[i] == CNT_LAST) begin
                    db_next[i]  = s[i];
                    cnt_next[i] = '0;
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            db            <= '1;
            press_pulse   <= '0;
            release_pulse <= '0;
            for (int i = 0; i < 4; i++)
                cnt[i] <= '0;
        end else begin
            db            <= db_next;
            press_pulse   <= db & ~db_next;
            release_pulse <= ~db & db_next;
            for (int i = 0; i < 4; i++)
                cnt[i] <= cnt_next[i];
        end
    end

    // new game overrides a coincident pause press
    always_ff @(posedge clk) begin
        if (!reset_n)
            paused <= 1'b0;
        else if (press_pulse[1])
            paused <= 1'b0;
        else if (press_pulse[0])
            paused <= ~paused;
    end

    assign bus.pressed       = ~db;
    assign bus.press_pulse   = press_pulse;
    assign bus.release_pulse = release_pulse;
    assign bus.paused        = paused;
    assign bus.new_game      = press_pulse[1];
    assign bus.paddle_up     = ~db[2] & db[3];
    assign bus.paddle_down   = ~db[3] & db[2];
    assign bus.tick          = tick;
endmodule

// File: tb/tb_solo_squash_inputs.sv
// tb/tb_solo_squash_inputs.sv - directed-vector bench for solo_squash_inputs
module tb_solo_squash_inputs;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    solo_squash_inputs_if bus ();

    solo_squash_inputs #(
        .TICK_DIV    (4),
        .DB_COUNT    (3),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_level(input int idx, input logic lvl, output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (bus.pressed[idx] !== lvl && lat < 40);
    endtask

    function automatic logic [16:0] all_outs();
        return {bus.pressed, bus.press_pulse, bus.release_pulse, bus.paused,
                bus.new_game, bus.paddle_up, bus.paddle_down, bus.tick};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int extra;
        int seen;
        int guard;
        logic bad;

        // 1: reset state and tick cadence
        bus.btn_n = 4'hF;
        reset_n   = 1'b0;
        repeat (3) step();
        check("reset_outs", 32'(all_outs()), 32'h0);
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("tick_c%0d", k + 1), 32'(bus.tick), 32'((k % 4) == 3));
        end

        // 2: up key press and release
        bus.btn_n[2] = 1'b0;
        wait_level(2, 1'b1, lat);
        check("up_latency_ok", 32'(lat >= 11 && lat <= 15), 32'h1);
        check("up_press_pulse", 32'(bus.press_pulse), 32'h4);
        check("up_paddle", 32'({bus.paddle_up, bus.paddle_down}), 32'h2);
        step();
        check("up_pulse_width", 32'(bus.press_pulse), 32'h0);
        bus.btn_n[2] = 1'b1;
        wait_level(2, 1'b0, lat);
        check("up_release_pulse", 32'(bus.release_pulse), 32'h4);
        check("up_paddle_off", 32'(bus.paddle_up), 32'h0);
        step();
        check("up_release_width", 32'(bus.release_pulse), 32'h0);

        // 3: bouncing down key, then both paddle keys held
        bad = 1'b0;
        for (int r = 0; r < 3; r++) begin
            bus.btn_n[3] = 1'b0;
            repeat (5) begin step(); bad |= bus.pressed[3] | bus.press_pulse[3]; end
            bus.btn_n[3] = 1'b1;
            repeat (2) begin step(); bad |= bus.pressed[3] | bus.press_pulse[3]; end
        end
        check("bounce_ignored", 32'(bad), 32'h0);
        bus.btn_n[3] = 1'b0;
        wait_level(3, 1'b1, lat);
        check("down_latency_ok", 32'(lat >= 11 && lat <= 15), 32'h1);
        check("down_press_pulse", 32'(bus.press_pulse[3]), 32'h1);
        check("down_paddle", 32'({bus.paddle_up, bus.paddle_down}), 32'h1);
        extra = 0;
        repeat (20) begin step(); extra += int'(bus.press_pulse[3]); end
        check("down_single_pulse", 32'(extra), 32'h0);
        bus.btn_n[2] = 1'b0;
        wait_level(2, 1'b1, lat);
        check("both_pressed", 32'(bus.pressed), 32'hC);
        check("both_paddles_off", 32'({bus.paddle_up, bus.paddle_down}), 32'h0);
        bus.btn_n[3:2] = 2'b11;
        wait_level(2, 1'b0, lat);
        wait_level(3, 1'b0, lat);
        check("both_released", 32'(bus.pressed), 32'h0);

        // 4: two pause presses toggle 0 -> 1 -> 0
        for (int p = 0; p < 2; p++) begin
            bus.btn_n[0] = 1'b0;
            wait_level(0, 1'b1, lat);
            check($sformatf("pause%0d_pulse", p), 32'(bus.press_pulse[0]), 32'h1);
            check($sformatf("pause%0d_before", p), 32'(bus.paused), 32'(p == 1));
            step();
            check($sformatf("pause%0d_after", p), 32'(bus.paused), 32'(p == 0));
            bus.btn_n[0] = 1'b1;
            wait_level(0, 1'b0, lat);
        end

        // 5: pause again, then pause and new game together
        bus.btn_n[0] = 1'b0;
        wait_level(0, 1'b1, lat);
        bus.btn_n[0] = 1'b1;
        wait_level(0, 1'b0, lat);
        check("setup_paused", 32'(bus.paused), 32'h1);
        bus.btn_n[1:0] = 2'b00;
        wait_level(0, 1'b1, lat);
        check("both_pulses", 32'(bus.press_pulse), 32'h3);
        check("new_game_strobe", 32'(bus.new_game), 32'h1);
        check("paused_hold", 32'(bus.paused), 32'h1);
        step();
        check("new_game_wins", 32'(bus.paused), 32'h0);
        check("new_game_width", 32'(bus.new_game), 32'h0);
        bus.btn_n[1:0] = 2'b11;
        wait_level(0, 1'b0, lat);
        wait_level(1, 1'b0, lat);
        repeat (6) step();

        // 6: reset in the middle of a debounce
        bus.btn_n[0] = 1'b0;
        step();
        step();
        seen  = 0;
        guard = 0;
        while (seen < 2 && guard < 20) begin
            if (bus.tick) seen++;
            step();
            guard++;
        end
        check("mid_not_pressed", 32'(bus.pressed[0]), 32'h0);
        reset_n = 1'b0;
        step();
        check("mid_reset_outs", 32'(all_outs()), 32'h0);
        reset_n = 1'b1;
        wait_level(0, 1'b1, lat);
        check("post_reset_latency", 32'(lat), 32'd12);
        check("post_reset_pulse", 32'(bus.press_pulse), 32'h1);
        check("post_reset_no_rel", 32'(bus.release_pulse), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
